input_debouncer: RTL and testbench

//  Conditions a raw asynchronous single-bit input (switch or button) into a clean, glitch-free level in the clk domain.

---
 rtl/input_debouncer_pkg.sv | 16 +
 rtl/bit_synchronizer.sv | 22 ++
 rtl/input_debouncer.sv | 110 +++++++++++
 tb/tb_input_debouncer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and glitch counter width.
package input_debouncer_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_e;

  localparam int GLITCH_CNT_W = 8;

  // Saturating increment for the glitch counter.
  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (v == {GLITCH_CNT_W{1'b1}}) ? v : v + GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// STAGES-deep flop chain bringing an asynchronous bit into the clk domain.
// Synchronous reset loads every flop with INIT.
module bit_synchronizer #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) r_chain <= {STAGES{INIT}};
    else     r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input: synchronizer, then a level qualifier FSM.
// Optional rejected-change counter enabled by INPUT_DEBOUNCER_GLITCH_CNT_EN.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out,
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic busy
);

  localparam int             CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STAB_C = CNT_W'(STABLE_CYCLES);

  logic             w_sync_q;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_out, w_out_nxt;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (data_in),
    .o_q (w_sync_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_out   <= INIT_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // cnt never exceeds STABLE_CYCLES-1 while qualifying, so the increment cannot wrap.
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      ST_STABLE: begin
        if (w_sync_q != r_out) begin
          if (STABLE_CYCLES == 1) begin
            w_out_nxt = w_sync_q;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_QUALIFY;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_QUALIFY: begin
        if (w_sync_q != r_out) begin
          if (w_cnt_inc == STAB_C) begin
            w_out_nxt   = w_sync_q;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

  assign data_out = r_out;
  assign busy     = (r_state == ST_QUALIFY);

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic                    w_abort;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  // A bounce back to the current level while qualifying is a rejected change.
  assign w_abort = (r_state == ST_QUALIFY) && (w_sync_q == r_out);

  always_ff @(posedge clk) begin
    if (rst)          r_glitch_cnt <= '0;
    else if (w_abort) r_glitch_cnt <= sat_inc(r_glitch_cnt);
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: default build and a STABLE_CYCLES=1 build side by side.
module tb_input_debouncer;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b0;
  logic d0_out, d0_busy, d1_out, d1_busy;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] d0_gl, d1_gl;
`endif

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4), .INIT_LEVEL(1'b0)) dut0 (
    .clk (clk), .rst (rst), .data_in (data_in), .data_out (d0_out),
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    .glitch_cnt (d0_gl),
`endif
    .busy (d0_busy)
  );

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1), .INIT_LEVEL(1'b0)) dut1 (
    .clk (clk), .rst (rst), .data_in (data_in), .data_out (d1_out),
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    .glitch_cnt (d1_gl),
`endif
    .busy (d1_busy)
  );

  typedef struct packed {
    logic       out;
    logic       busy;
    logic [7:0] gl;
  } exp_t;

  // Behavioural reference: input delay line, then a run-length rule on "differs from output".
  typedef struct packed {
    logic [15:0] dl;
    logic        out;
    int          run;
    int          gl;
  } mdl_t;

  exp_t q0[$];
  exp_t q1[$];
  mdl_t m0, m1;
  int checks = 0;
  int failures = 0;

  function automatic mdl_t step(input mdl_t m, input logic r, input logic d, input int stab);
    logic seen;
    if (r) begin
      m.dl = '0; m.out = 1'b0; m.run = 0; m.gl = 0;
      return m;
    end
    seen = m.dl[SYNC-1];
    m.dl = {m.dl[14:0], d};
    if (seen != m.out) begin
      m.run = m.run + 1;
      if (m.run >= stab) begin
        m.out = seen;
        m.run = 0;
      end
    end else begin
      if (m.run > 0 && m.gl < 255) m.gl = m.gl + 1;
      m.run = 0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic d);
    @(negedge clk);
    rst = r;
    data_in = d;
    m0 = step(m0, r, d, 4);
    m1 = step(m1, r, d, 1);
    q0.push_back('{out: m0.out, busy: (m0.run != 0), gl: 8'(m0.gl)});
    q1.push_back('{out: m1.out, busy: (m1.run != 0), gl: 8'(m1.gl)});
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, d);
  endtask

  // Monitor: every rising edge the DUTs present a new state; compare with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("out0", int'(d0_out), int'(e.out));
        chk("busy0", int'(d0_busy), int'(e.busy));
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        chk("glitch0", int'(d0_gl), int'(e.gl));
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("out1", int'(d1_out), int'(e.out));
        chk("busy1", int'(d1_busy), int'(e.busy));
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        chk("glitch1", int'(d1_gl), int'(e.gl));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m0 = '0;
    m1 = '0;
    // Reset with the input high, then settle low.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    hold(1'b0, 6);
    // Clean step up and back down.
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Short pulse of 3 cycles.
    hold(1'b1, 3);
    hold(1'b0, 8);
    // Bounce train then a held high.
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
    hold(1'b1, 12);
    hold(1'b0, 10);
    // Reset mid-qualification, input stays high during the reset cycle.
    hold(1'b1, 4);
    drive(1'b1, 1'b1);
    hold(1'b0, 10);
    // Many aborts to saturate the glitch counter.
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    hold(1'b0, 6);
    // Randomized segments with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) drive(1'b1, 1'($urandom_range(0, 1)));
      else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end
    hold(1'b0, 8);
    repeat (3) @(negedge clk);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
